// File: rtl/argmax_classifier_pkg.sv
// Shared definitions for the argmax classifier output stage.
//   - FP32 field positions (sign / exponent / mantissa).
//   - FSM state encodings.
//   - fp32_key(): maps FP32 bits onto an unsigned key whose integer order is a
//     total order over the float values (+0 ranks above -0).
package argmax_classifier_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_MSB  = 22;
    localparam int unsigned MAN_LSB  = 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Negative values: invert all bits so larger magnitude sorts lower.
    // Positive values: set the MSB so every positive sorts above every negative.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return x[SIGN_BIT] ? ~x : (x | 32'h8000_0000);
    endfunction

endpackage

// File: rtl/argmax_classifier_fp32_gt.sv
// Combinational FP32 strict greater-than comparator.
// Ports:
//   a, b    in   32  FP32 operands
//   a_gt_b  out  1   1 when key(a) > key(b); NaN/Inf are ordered by key only
module fp32_gt
    import argmax_classifier_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b
);

    always_comb begin
        a_gt_b = fp32_key(a) > fp32_key(b);
    end

endmodule

// File: rtl/argmax_classifier.sv
// Argmax output stage following the tanh activation block.
// Latches the activation vector when start is seen in IDLE or DONE, then scans
// one element per cycle, keeping the first index of the largest value.
// Ports:
//   clk               in   1                        rising-edge clock
//   reset             in   1                        synchronous, active-high
//   start             in   1                        vector valid (tanh Finished)
//   activatedNeurons  in   DATA_WIDTH*No_of_Neurons neuron k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Finished          out  1                        result valid level
//   maxIndex          out  INDEX_WIDTH              index of maximum element
//   maxValue          out  DATA_WIDTH               FP32 bits of maximum element
module argmax_classifier
    import argmax_classifier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned No_of_Neurons = 8,
    parameter int unsigned INDEX_WIDTH   = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [DATA_WIDTH*No_of_Neurons-1:0] activatedNeurons,
    output logic                                Finished,
    output logic [INDEX_WIDTH-1:0]              maxIndex,
    output logic [DATA_WIDTH-1:0]               maxValue
);

    logic [1:0]                          state_q, state_d;
    logic [DATA_WIDTH*No_of_Neurons-1:0] vec_q, vec_d;
    logic [INDEX_WIDTH-1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]               best_val_q, best_val_d;
    logic [INDEX_WIDTH-1:0]              best_idx_q, best_idx_d;
    logic                                fin_q, fin_d;
    logic [INDEX_WIDTH-1:0]              max_idx_q, max_idx_d;
    logic [DATA_WIDTH-1:0]               max_val_q, max_val_d;

    logic [DATA_WIDTH-1:0]               elems [No_of_Neurons];
    logic [DATA_WIDTH-1:0]               cand;
    logic                                cand_gt;
    logic [DATA_WIDTH-1:0]               new_val;
    logic [INDEX_WIDTH-1:0]              new_idx;
    logic                                last;

    for (genvar k = 0; k < No_of_Neurons; k++) begin : g_elems
        assign elems[k] = vec_q[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign cand = elems[cnt_q];
    assign last = (cnt_q == INDEX_WIDTH'(No_of_Neurons - 1));

    fp32_gt u_gt (
        .a      (cand),
        .b      (best_val_q),
        .a_gt_b (cand_gt)
    );

    // Strictly greater only, so ties keep the lower index.
    assign new_val = cand_gt ? cand  : best_val_q;
    assign new_idx = cand_gt ? cnt_q : best_idx_q;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        fin_d      = fin_q;
        max_idx_d  = max_idx_q;
        max_val_d  = max_val_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d      = activatedNeurons;
                    best_val_d = activatedNeurons[DATA_WIDTH-1:0];
                    best_idx_d = '0;
                    cnt_d      = INDEX_WIDTH'(1);
                    fin_d      = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                best_val_d = new_val;
                best_idx_d = new_idx;
                cnt_d      = cnt_q + INDEX_WIDTH'(1);
                if (last) begin
                    // Outputs take the final best directly; no intermediate updates.
                    max_val_d = new_val;
                    max_idx_d = new_idx;
                    fin_d     = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            fin_q      <= 1'b0;
            max_idx_q  <= '0;
            max_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            fin_q      <= fin_d;
            max_idx_q  <= max_idx_d;
            max_val_q  <= max_val_d;
        end
    end

    assign Finished = fin_q;
    assign maxIndex = max_idx_q;
    assign maxValue = max_val_q;

endmodule
